multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle RV32I main controller: sequences fetch/decode/execute/mem/writeback, drives datapath mux selects and alu_op.

---
 rtl/rv32i_ctrl_pkg.sv | 52 +++++
 rtl/ctrl_out_decode.sv | 68 ++++++
 rtl/multicycle_ctrl_fsm.sv | 127 ++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath select codes and the packed control word driven by ctrl_out_decode.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Controls that depend on state alone; ir_write/pc_write are qualified in the top.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Pure combinational state -> control word decode for the multi-cycle controller.
module ctrl_out_decode
  import rv32i_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req    = 1'b1;
        cw.alu_src_a  = SRCA_PC;
        cw.alu_src_b  = SRCB_FOUR;
        cw.result_src = RES_ALU;
      end
      // Branch/jump target is computed speculatively into ALUOut here.
      S_DECODE: begin
        cw.alu_src_a = SRCA_OLDPC;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        cw.mem_req = 1'b1;
        cw.adr_src = 1'b1;
      end
      S_MEMWB: begin
        cw.result_src = RES_MEM;
        cw.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req = 1'b1;
        cw.mem_we  = 1'b1;
        cw.adr_src = 1'b1;
      end
      S_EXECR: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_RS2;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_ALUWB: begin
        cw.result_src = RES_ALUOUT;
        cw.reg_write  = 1'b1;
      end
      S_BEQ: begin
        cw.alu_src_a  = SRCA_RS1;
        cw.alu_src_b  = SRCB_RS2;
        cw.alu_op     = ALUOP_SUB;
        cw.result_src = RES_ALUOUT;
      end
      S_JAL: begin
        cw.alu_src_a  = SRCA_OLDPC;
        cw.alu_src_b  = SRCB_FOUR;
        cw.result_src = RES_ALUOUT;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main controller: FSM, retired-instruction counter and memory handshake.
// Optional ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state and raise 'illegal'.
module multicycle_ctrl_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] instret,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [3:0]       state_o
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             ir_write_next, pc_write_next, retire;
  ctrl_word_t       cw;

  ctrl_out_decode u_dec (
    .state (state_reg),
    .cw    (cw)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    ir_write_next = 1'b0;
    pc_write_next = 1'b0;
    retire        = 1'b0;
    case (state_reg)
      S_FETCH: if (mem_ready) begin
        ir_write_next = 1'b1;
        pc_write_next = 1'b1;
        state_next    = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_FETCH;
            retire     = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: if (mem_ready) begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: state_next = S_ALUWB;
      S_ALUWB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        pc_write_next = zero;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      // jal writes PC now and retires after rd <= oldPC+4 in ALUWB.
      S_JAL: begin
        pc_write_next = 1'b1;
        state_next    = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: state_next = S_TRAP;
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Everything is held low while reset is asserted, including the abandoned mem_req.
  assign mem_req    = reset & cw.mem_req;
  assign mem_we     = reset & cw.mem_we;
  assign adr_src    = reset & cw.adr_src;
  assign reg_write  = reset & cw.reg_write;
  assign ir_write   = reset & ir_write_next;
  assign pc_write   = reset & pc_write_next;
  assign alu_src_a  = reset ? cw.alu_src_a  : 2'b00;
  assign alu_src_b  = reset ? cw.alu_src_b  : 2'b00;
  assign result_src = reset ? cw.result_src : 2'b00;
  assign alu_op     = reset ? cw.alu_op     : 2'b00;
  assign instret    = reset ? instret_reg   : '0;
  assign state_o    = reset ? state_reg     : 4'd0;
`ifdef ILLEGAL_TRAP_EN
  assign illegal    = reset & (state_reg == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: instruction-level model builds the
// expected per-cycle control trace from random instructions and wait states.
module tb_multicycle_ctrl_fsm;
  import rv32i_ctrl_pkg::*;

  localparam int CNT_W = 8;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [6:0]       opcode = 7'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src, alu_op;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .instret    (instret),
`ifdef ILLEGAL_TRAP_EN
    .illegal    (illegal),
`endif
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int               errors = 0;
  int               checks = 0;
  int               cyc_count = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  string            cur = "init";

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s/%s @%0t: got %0h required %0h", cur, name, $time, act, req);
    end
  endtask

  function automatic logic [13:0] ctl(input logic mreq, mwe, adr, irw, pcw, rw,
                                      input logic [1:0] a, b, res, op);
    return {mreq, mwe, adr, irw, pcw, rw, a, b, res, op};
  endfunction

  function automatic logic [13:0] dut_ctl();
    return {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, result_src, alu_op};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic bit known(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare, then account retire.
  task automatic step(input logic [3:0] st, input logic [13:0] exp_ctl, input logic mr,
                      input logic z, input logic [6:0] opc, input logic ret, input logic ill);
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    opcode    = opc;
    #1;
    cyc_count++;
    chk("ctrl", 32'(dut_ctl()), 32'(exp_ctl));
    chk("state", 32'(state_o), 32'(st));
    chk("instret", 32'(instret), 32'(exp_instret));
`ifdef ILLEGAL_TRAP_EN
    chk("illegal", 32'(illegal), 32'(ill));
`else
    if (ill) chk("illegal_in_nop_build", 32'(ill), 32'(0));
`endif
    if (ret) exp_instret = exp_instret + 1'b1;
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i < fw; i++)
      step(S_FETCH, ctl(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00), 1'b0, rbit(), rop(), 1'b0, 1'b0);
    step(S_FETCH, ctl(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00), 1'b1, rbit(), rop(), 1'b0, 1'b0);
  endtask

  // Expected trace of one whole instruction; fw/mw are fetch/data wait cycles.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input logic z,
                           output int ncyc);
    int n0;
    n0 = cyc_count;
    fetch(fw);
    step(S_DECODE, ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00), rbit(), rbit(), opc,
         !known(opc) && !TRAP_EN, 1'b0);
    if (opc == OP_LW) begin
      step(S_MEMADR, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), rbit(), rbit(), opc, 0, 0);
      for (int i = 0; i < mw; i++)
        step(S_MEMRD, ctl(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0, rbit(), opc, 0, 0);
      step(S_MEMRD, ctl(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1, rbit(), opc, 0, 0);
      step(S_MEMWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00), rbit(), rbit(), opc, 1, 0);
    end else if (opc == OP_SW) begin
      step(S_MEMADR, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), rbit(), rbit(), opc, 0, 0);
      for (int i = 0; i < mw; i++)
        step(S_MEMWR, ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0, rbit(), opc, 0, 0);
      step(S_MEMWR, ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1, rbit(), opc, 1, 0);
    end else if (opc == OP_R || opc == OP_I) begin
      if (opc == OP_R)
        step(S_EXECR, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10), rbit(), rbit(), opc, 0, 0);
      else
        step(S_EXECI, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), rbit(), rbit(), opc, 0, 0);
      step(S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), rbit(), rbit(), opc, 1, 0);
    end else if (opc == OP_BEQ) begin
      step(S_BEQ, ctl(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 2'b01), rbit(), z, opc, 1, 0);
    end else if (opc == OP_JAL) begin
      step(S_JAL, ctl(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00), rbit(), rbit(), opc, 0, 0);
      step(S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), rbit(), rbit(), opc, 1, 0);
    end else if (TRAP_EN) begin
      for (int i = 0; i < 4; i++)
        step(S_TRAP, 14'd0, rbit(), rbit(), opc, 0, 1);
    end
    ncyc = cyc_count - n0;
    $display("instr opc=%b fw=%0d mw=%0d z=%0b cycles=%0d exp_instret=%0d",
             opc, fw, mw, z, ncyc, exp_instret);
  endtask

  task automatic settle_chk_instret(input string name, input logic [CNT_W-1:0] req);
    @(posedge clk);
    #1;
    chk(name, 32'(instret), 32'(req));
  endtask

  initial begin
    int         n;
    int         k;
    logic [6:0] opc;
    logic [6:0] kinds [6];
    kinds = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    cur = "reset";
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("rst_ctrl", 32'(dut_ctl()), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;

    cur = "add";
    run_instr(OP_R, 0, 0, 1'b0, n);
    settle_chk_instret("add_instret", 8'd1);
    cur = "lw";
    run_instr(OP_LW, 0, 2, 1'b0, n);
    chk("lw_cycles", 32'(n), 32'd7);
    cur = "sw";
    run_instr(OP_SW, 0, 0, 1'b0, n);
    chk("sw_cycles", 32'(n), 32'd4);
    settle_chk_instret("sw_instret", 8'd3);
    cur = "beq_taken";
    run_instr(OP_BEQ, 0, 0, 1'b1, n);
    chk("beq1_cycles", 32'(n), 32'd3);
    cur = "beq_not";
    run_instr(OP_BEQ, 0, 0, 1'b0, n);
    chk("beq0_cycles", 32'(n), 32'd3);
    cur = "jal";
    run_instr(OP_JAL, 0, 0, 1'b0, n);
    chk("jal_cycles", 32'(n), 32'd4);
    cur = "lw0";
    run_instr(OP_LW, 0, 0, 1'b0, n);
    chk("lw0_cycles", 32'(n), 32'd5);
    settle_chk_instret("dir_instret", 8'd7);

    cur = "random";
    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, TRAP_EN ? 5 : 6);
      if (k == 6) begin
        do opc = rop(); while (known(opc));
      end else begin
        opc = kinds[k];
      end
      run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), n);
    end

    cur = "reset_memrd";
    fetch(1);
    step(S_DECODE, ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00), 1'b0, 1'b0, OP_LW, 0, 0);
    step(S_MEMADR, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), 1'b0, 1'b0, OP_LW, 0, 0);
    step(S_MEMRD, ctl(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0, 1'b0, OP_LW, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_mid_ctrl", 32'(dut_ctl()), 32'd0);
    chk("rst_mid_state", 32'(state_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rel_mem_req", 32'(mem_req), 32'd1);
    chk("rel_state", 32'(state_o), 32'(S_FETCH));
    chk("rel_instret", 32'(instret), 32'd0);
    exp_instret = '0;

    cur = "wrap";
    while (exp_instret != {CNT_W{1'b1}})
      run_instr(OP_I, 0, 0, 1'b0, n);
    settle_chk_instret("pre_wrap", 8'hFF);
    run_instr(OP_R, 0, 0, 1'b0, n);
    settle_chk_instret("post_wrap", 8'h00);

    cur = "illegal";
    run_instr(7'h7F, 0, 0, 1'b0, n);
    if (TRAP_EN) begin
      settle_chk_instret("trap_no_retire", 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("trap_cleared_state", 32'(state_o), 32'(S_FETCH));
    end else begin
      chk("nop_cycles", 32'(n), 32'd2);
      settle_chk_instret("nop_retire", 8'h01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
